// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the counter family
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled cycles into one TICK every PRESCALE cycles
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);

   localparam int PS_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
   end

   logic [PS_W-1:0] ps_q;
   logic [PS_W-1:0] ps_d;

   always_comb begin
      ps_d = ps_q;
      if (CLR) begin
         ps_d = '0;
      end else if (EN) begin
         ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end

   // With PRESCALE=1 ps_q is stuck at 0 == PS_LAST, so TICK follows EN.
   assign TICK = EN & (ps_q == PS_LAST);

endmodule

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - modulo-N up/down counter with load, prescaler and wrap/saturate modes
module mod_n_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int MODULUS  = 25,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             UP,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] QBit,
   output logic             TC,
   output logic             CARRY
);

   localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
   localparam logic SAT_MODE = (SATURATE == CNT_SAT);

   if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic             step;
   logic             ps_clr;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   assign ps_clr = CLR | LOAD;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .CLR  (ps_clr),
      .TICK (step)
   );

   // Terminal values are tested explicitly, so no WIDTH+1-bit sum is ever needed.
   always_comb begin
      q_d = q_q;
      if (CLR) begin
         q_d = '0;
      end else if (LOAD) begin
         q_d = (LOAD_VAL > Q_MAX) ? Q_MAX : LOAD_VAL;
      end else if (step) begin
         if (UP == DIR_UP) begin
            q_d = (q_q == Q_MAX) ? (SAT_MODE ? Q_MAX : '0) : q_q + 1'b1;
         end else begin
            q_d = (q_q == '0) ? (SAT_MODE ? '0 : Q_MAX) : q_q - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign QBit  = q_q;
   assign TC    = ((UP == DIR_UP) & (q_q == Q_MAX)) | ((UP == DIR_DOWN) & (q_q == '0));
   assign CARRY = step & TC & ~CLR & ~LOAD & ~RST & ~SAT_MODE;

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - self-checking bench for mod_n_counter
module tb_mod_n_counter;

   logic       CLK;
   logic       RST;
   logic       EN;
   logic       UP;
   logic       CLR;
   logic       LOAD;
   logic [4:0] LOAD_VAL;

   logic [4:0] dflt_q, sat_q, ps_q, c1_q;
   logic       dflt_tc, sat_tc, ps_tc, c1_tc;
   logic       dflt_carry, sat_carry, ps_carry, c1_carry;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_main[$];
   int exp_aux[$];

   mod_n_counter dut (
      .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .QBit(dflt_q), .TC(dflt_tc), .CARRY(dflt_carry)
   );

   mod_n_counter #(.SATURATE(1)) dut_sat (
      .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .QBit(sat_q), .TC(sat_tc), .CARRY(sat_carry)
   );

   mod_n_counter #(.PRESCALE(4)) dut_ps4 (
      .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .QBit(ps_q), .TC(ps_tc), .CARRY(ps_carry)
   );

   mod_n_counter dut_c1 (
      .CLK(CLK), .RST(RST), .EN(dflt_carry), .UP(UP), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .QBit(c1_q), .TC(c1_tc), .CARRY(c1_carry)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic next_cycle();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      RST = 1'b1; EN = 1'b0; UP = 1'b1; CLR = 1'b0; LOAD = 1'b0; LOAD_VAL = '0;
      next_cycle();
      RST = 1'b0;
      exp_main.delete();
      exp_aux.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_tests++;
      if ({dflt_q, sat_q, ps_q, c1_q} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_q: got %0d/%0d/%0d/%0d expected 0/0/0/0", dflt_q, sat_q, ps_q, c1_q);
      end
      n_tests++;
      if ({dflt_tc, dflt_carry} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_tc_up: got tc=%0b carry=%0b expected tc=0 carry=0", dflt_tc, dflt_carry);
      end
      UP = 1'b0;
      #1;
      n_tests++;
      if ({dflt_tc, sat_tc, dflt_carry} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_tc_down: got tc=%0b sat_tc=%0b carry=%0b expected 1 1 0", dflt_tc, sat_tc, dflt_carry);
      end
   endtask

   task automatic test_count_up();
      int e, s;
      apply_reset();
      UP = 1'b1; EN = 1'b1;
      exp_main.push_back(0);
      exp_aux.push_back(0);
      for (int i = 0; i < 28; i++) begin
         #1;
         e = exp_main.pop_front();
         s = exp_aux.pop_front();
         n_tests++;
         if ({dflt_q, dflt_tc, dflt_carry} !== {5'(e), e == 24, e == 24}) begin
            n_fail++;
            $display("FAIL up_wrap[%0d]: got q=%0d tc=%0b carry=%0b expected q=%0d tc=%0b carry=%0b",
                     i, dflt_q, dflt_tc, dflt_carry, e, e == 24, e == 24);
         end
         n_tests++;
         if ({sat_q, sat_tc, sat_carry} !== {5'(s), s == 24, 1'b0}) begin
            n_fail++;
            $display("FAIL up_sat[%0d]: got q=%0d tc=%0b carry=%0b expected q=%0d tc=%0b carry=0",
                     i, sat_q, sat_tc, sat_carry, s, s == 24);
         end
         exp_main.push_back((i + 1) % 25);
         exp_aux.push_back((i + 1 > 24) ? 24 : i + 1);
         next_cycle();
      end
   endtask

   task automatic test_count_down();
      int  e, s;
      logic tc_e, tc_s;
      apply_reset();
      UP = 1'b0; EN = 1'b1;
      exp_main.push_back(0);
      exp_aux.push_back(0);
      for (int i = 0; i < 18; i++) begin
         if (i == 15) UP = 1'b1;
         #1;
         e = exp_main.pop_front();
         s = exp_aux.pop_front();
         tc_e = UP ? (e == 24) : (e == 0);
         tc_s = UP ? (s == 24) : (s == 0);
         n_tests++;
         if ({dflt_q, dflt_tc, dflt_carry} !== {5'(e), tc_e, tc_e}) begin
            n_fail++;
            $display("FAIL down_wrap[%0d]: got q=%0d tc=%0b carry=%0b expected q=%0d tc=%0b carry=%0b",
                     i, dflt_q, dflt_tc, dflt_carry, e, tc_e, tc_e);
         end
         n_tests++;
         if ({sat_q, sat_tc, sat_carry} !== {5'(s), tc_s, 1'b0}) begin
            n_fail++;
            $display("FAIL down_sat[%0d]: got q=%0d tc=%0b carry=%0b expected q=%0d tc=%0b carry=0",
                     i, sat_q, sat_tc, sat_carry, s, tc_s);
         end
         exp_main.push_back(UP ? e + 1 : ((e == 0) ? 24 : e - 1));
         exp_aux.push_back(UP ? s + 1 : s);
         next_cycle();
      end
   endtask

   task automatic test_prescale();
      int e;
      int en_edges;
      apply_reset();
      UP = 1'b1;
      en_edges = 0;
      exp_main.push_back(0);
      for (int i = 0; i < 24; i++) begin
         EN  = (i < 9 || i >= 12);
         RST = (i == 17);
         #1;
         e = exp_main.pop_front();
         n_tests++;
         if ({ps_q, ps_carry} !== {5'(e), 1'b0}) begin
            n_fail++;
            $display("FAIL prescale[%0d]: got q=%0d carry=%0b expected q=%0d carry=0", i, ps_q, ps_carry, e);
         end
         if (RST) en_edges = 0;
         else if (EN) en_edges++;
         exp_main.push_back(en_edges / 4);
         next_cycle();
      end
      RST = 1'b0;
      EN  = 1'b0;
   endtask

   task automatic test_load();
      int t_rst [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      int t_clr [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      int t_load[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      int t_val [9] = '{30, 5, 25, 24, 9, 20, 12, 0, 0};
      int t_exp [9] = '{24, 5, 24, 24, 0, 20, 0, 1, 2};
      int e;
      apply_reset();
      UP = 1'b1; EN = 1'b1;
      for (int i = 0; i < 9; i++) begin
         RST = 1'(t_rst[i]); CLR = 1'(t_clr[i]); LOAD = 1'(t_load[i]); LOAD_VAL = 5'(t_val[i]);
         #1;
         n_tests++;
         if (dflt_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL load_carry[%0d]: got carry=%0b expected 0", i, dflt_carry);
         end
         exp_main.push_back(t_exp[i]);
         next_cycle();
         #1;
         e = exp_main.pop_front();
         n_tests++;
         if (dflt_q !== 5'(e)) begin
            n_fail++;
            $display("FAIL load_q[%0d]: got q=%0d expected q=%0d", i, dflt_q, e);
         end
      end
      RST = 1'b0; CLR = 1'b0; LOAD = 1'b0; LOAD_VAL = '0; EN = 1'b0;
   endtask

   task automatic test_cascade();
      int e1, e2;
      int pulses;
      logic c_exp;
      apply_reset();
      UP = 1'b1; EN = 1'b1;
      pulses = 0;
      exp_main.push_back(0);
      exp_aux.push_back(0);
      for (int k = 0; k <= 625; k++) begin
         #1;
         e1 = exp_main.pop_front();
         e2 = exp_aux.pop_front();
         c_exp = (e1 == 24) && (e2 == 24);
         n_tests++;
         if ({dflt_q, c1_q, c1_carry} !== {5'(e1), 5'(e2), c_exp}) begin
            n_fail++;
            $display("FAIL cascade[%0d]: got q0=%0d q1=%0d carry1=%0b expected q0=%0d q1=%0d carry1=%0b",
                     k, dflt_q, c1_q, c1_carry, e1, e2, c_exp);
         end
         if (c1_carry === 1'b1) pulses++;
         if (k < 625) begin
            exp_main.push_back((k + 1) % 25);
            exp_aux.push_back(((k + 1) / 25) % 25);
            next_cycle();
         end
      end
      n_tests++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL cascade_pulses: got %0d carry pulses expected 1", pulses);
      end
      EN = 1'b0;
   endtask

   initial begin
      RST = 1'b0; EN = 1'b0; UP = 1'b1; CLR = 1'b0; LOAD = 1'b0; LOAD_VAL = '0;
      test_reset();
      test_count_up();
      test_count_down();
      test_prescale();
      test_load();
      test_cascade();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
